// File: rtl/channel_scheduler.sv
// Purpose : time-multiplexed note scheduler; one beat visits every channel in
//           ascending order, counts down sounding notes and fetches new ones.
// Latency : request pulses one cycle after the SCAN decision; a visit with no
//           fetch costs 2 cycles (SCAN, NEXT), a fetch adds the response waits.
// Backpr. : beats arriving while a scan is in progress are dropped and
//           flagged on o_overrun; the wait states hold indefinitely.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_note_stb          beat strobe (accepted only in IDLE)
//   i_chan_enable       per-channel enable mask
//   o_pattern_req/o_chan  one-cycle pattern fetch request and its channel
//   i_pattern_valid/i_pattern_len  pattern response (len 0 = rest)
//   o_pitch_req         one-cycle pitch lookup request (channel on o_chan)
//   i_pitch_valid       pitch lookup response
//   o_active            per-channel note-sounding flags
//   o_busy              high while a scan is in progress
//   o_frame_done        one-cycle pulse when the last channel is finished
//   o_overrun           one-cycle pulse when a beat is dropped
module channel_scheduler #(
  parameter int NUM_CHANNELS = 4,
  parameter int DUR_WIDTH    = 5,
  localparam int CHAN_WIDTH  = $clog2(NUM_CHANNELS)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_note_stb,
  input  logic [NUM_CHANNELS-1:0] i_chan_enable,
  output logic                    o_pattern_req,
  output logic [CHAN_WIDTH-1:0]   o_chan,
  input  logic                    i_pattern_valid,
  input  logic [DUR_WIDTH-1:0]    i_pattern_len,
  output logic                    o_pitch_req,
  input  logic                    i_pitch_valid,
  output logic [NUM_CHANNELS-1:0] o_active,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic                    o_overrun
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_PAT_WAIT,
    ST_PIT_WAIT,
    ST_NEXT
  } state_t;

  state_t                  state_q, state_d;
  logic [CHAN_WIDTH-1:0]   chan_q, chan_d;
  // Beats still to sound after the current one; zero means refetch on the
  // channel's next visit.
  logic [DUR_WIDTH-1:0]    remaining_q [NUM_CHANNELS];
  logic [DUR_WIDTH-1:0]    remaining_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] active_q, active_d;
  logic                    pattern_req_q, pattern_req_d;
  logic                    pitch_req_q, pitch_req_d;
  logic                    busy_q, busy_d;
  logic                    frame_done_q, frame_done_d;
  logic                    overrun_q, overrun_d;

  logic                    last_chan;
  logic                    chan_enabled;

  assign last_chan    = (chan_q == CHAN_WIDTH'(NUM_CHANNELS - 1));
  assign chan_enabled = i_chan_enable[chan_q];

  always_comb begin
    state_d       = state_q;
    chan_d        = chan_q;
    remaining_d   = remaining_q;
    active_d      = active_q;
    pattern_req_d = 1'b0;
    pitch_req_d   = 1'b0;
    frame_done_d  = 1'b0;
    // Any strobe outside IDLE is a dropped beat; the scan itself ignores it.
    overrun_d     = i_note_stb && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (i_note_stb) begin
          state_d = ST_SCAN;
          chan_d  = '0;
        end
      end

      ST_SCAN: begin
        if (!chan_enabled) begin
          // Clearing the count forces a fresh fetch once re-enabled.
          remaining_d[chan_q] = '0;
          active_d[chan_q]    = 1'b0;
          state_d             = ST_NEXT;
        end else if (remaining_q[chan_q] != '0) begin
          remaining_d[chan_q] = remaining_q[chan_q] - DUR_WIDTH'(1);
          state_d             = ST_NEXT;
        end else begin
          pattern_req_d = 1'b1;
          state_d       = ST_PAT_WAIT;
        end
      end

      ST_PAT_WAIT: begin
        if (i_pattern_valid) begin
          if (i_pattern_len != '0) begin
            // The fetch beat itself is the first sounding beat.
            remaining_d[chan_q] = i_pattern_len - DUR_WIDTH'(1);
            active_d[chan_q]    = 1'b1;
            pitch_req_d         = 1'b1;
            state_d             = ST_PIT_WAIT;
          end else begin
            remaining_d[chan_q] = '0;
            active_d[chan_q]    = 1'b0;
            state_d             = ST_NEXT;
          end
        end
      end

      ST_PIT_WAIT: begin
        if (i_pitch_valid) begin
          state_d = ST_NEXT;
        end
      end

      ST_NEXT: begin
        if (last_chan) begin
          frame_done_d = 1'b1;
          chan_d       = '0;
          state_d      = ST_IDLE;
        end else begin
          chan_d  = chan_q + CHAN_WIDTH'(1);
          state_d = ST_SCAN;
        end
      end

      default: begin
        state_d = ST_IDLE;
        chan_d  = '0;
      end
    endcase

    // Registered copy of "not idle" so o_busy tracks the state register.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      chan_q        <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        remaining_q[i] <= '0;
      end
      active_q      <= '0;
      pattern_req_q <= 1'b0;
      pitch_req_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      chan_q        <= chan_d;
      remaining_q   <= remaining_d;
      active_q      <= active_d;
      pattern_req_q <= pattern_req_d;
      pitch_req_q   <= pitch_req_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
    end
  end

  assign o_pattern_req = pattern_req_q;
  assign o_chan        = chan_q;
  assign o_pitch_req   = pitch_req_q;
  assign o_active      = active_q;
  assign o_busy        = busy_q;
  assign o_frame_done  = frame_done_q;
  assign o_overrun     = overrun_q;

  // Request strobes come from different states and can never coincide.
  a_req_exclusive: assert property (@(posedge i_clk) disable iff (i_rst)
    !(pattern_req_q && pitch_req_q));

  a_busy_tracks_state: assert property (@(posedge i_clk) disable iff (i_rst)
    busy_q == (state_q != ST_IDLE));

endmodule
